// File: rtl/bitstream_monitor.sv
// Serial bitstream monitor: overlapping pattern detection, saturating match and
// rising-edge counters, stuck-stream flag and last-sample level. All outputs registered.
module bitstream_monitor #(
   parameter int unsigned          PAT_LEN   = 4,
   parameter logic [PAT_LEN-1:0]   PATTERN   = 4'b1011,
   parameter int unsigned          CNT_W     = 8,
   parameter int unsigned          STUCK_LIM = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] rise_cnt,
   output logic             stuck,
   output logic             level
);

   localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
   localparam int unsigned RUN_W  = $clog2(STUCK_LIM + 1);

   localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PAT_LEN - 1);
   localparam logic [RUN_W-1:0]  RUN_LIM   = RUN_W'(STUCK_LIM);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [PAT_LEN-1:0] window_q, window_d, win_next;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               have_prev_q, have_prev_d;
   logic [0:0]         state_q, state_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
   logic               stuck_q, stuck_d;
   logic               level_q, level_d;

   // NOTE: every next-state variable takes a default first so no latch is inferred.
   always_comb begin
      win_next    = {window_q[PAT_LEN-2:0], din};
      window_d    = window_q;
      fill_d      = fill_q;
      run_d       = run_q;
      have_prev_d = have_prev_q;
      state_d     = state_q;
      match_d     = 1'b0;
      match_cnt_d = match_cnt_q;
      rise_cnt_d  = rise_cnt_q;
      stuck_d     = stuck_q;
      level_d     = level_q;

      if (en) begin
         window_d    = win_next;
         level_d     = din;
         have_prev_d = 1'b1;

         if (state_q == ST_FILL) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == LAST_FILL) state_d = ST_RUN;
         end

         // The sample that completes the fill is already eligible to match.
         if ((state_d == ST_RUN) && (win_next == PATTERN)) begin
            match_d = 1'b1;
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
         end

         if (have_prev_q && !level_q && din && (rise_cnt_q != '1))
            rise_cnt_d = rise_cnt_q + 1'b1;

         if (!have_prev_q || (din != level_q)) run_d = RUN_W'(1);
         else if (run_q != RUN_LIM)             run_d = run_q + 1'b1;

         stuck_d = (run_d == RUN_LIM);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         window_q    <= '0;
         fill_q      <= '0;
         run_q       <= '0;
         have_prev_q <= 1'b0;
         state_q     <= ST_FILL;
         match_q     <= 1'b0;
         match_cnt_q <= '0;
         rise_cnt_q  <= '0;
         stuck_q     <= 1'b0;
         level_q     <= 1'b0;
      end else begin
         window_q    <= window_d;
         fill_q      <= fill_d;
         run_q       <= run_d;
         have_prev_q <= have_prev_d;
         state_q     <= state_d;
         match_q     <= match_d;
         match_cnt_q <= match_cnt_d;
         rise_cnt_q  <= rise_cnt_d;
         stuck_q     <= stuck_d;
         level_q     <= level_d;
      end
   end

   assign match     = match_q;
   assign match_cnt = match_cnt_q;
   assign rise_cnt  = rise_cnt_q;
   assign stuck     = stuck_q;
   assign level     = level_q;

endmodule
